// File: rtl/uart_pkg.sv
// Shared UART constants and the receiver FSM state type.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int UART_DIV_W     = 12;
    localparam int UART_OVS       = 16;
    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_os_if.sv
// Received-word bus of the UART receiver: word, valid strobe and error strobes.
interface uart_rx_os_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS
);

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 parity_err;

    modport master (output rx_data, rx_valid, frame_err, parity_err);
    modport slave  (input  rx_data, rx_valid, frame_err, parity_err);

endinterface

// File: rtl/os_tick_gen.sv
// Oversample tick generator: counts 0..div_lim-1 and pulses tick on the last count.
// While hold is high the counter sits at 0 so the tick phase follows the start edge.
module os_tick_gen
    import uart_pkg::*;
(
    input  logic                  CLK100MHZ,
    input  logic                  resetn,
    input  logic [UART_DIV_W-1:0] div_lim,
    input  logic                  hold,
    output logic                  tick
);

    logic [UART_DIV_W-1:0] cnt;
    logic [UART_DIV_W-1:0] last;

    // div_lim of 0 or 1 both collapse to a tick every cycle.
    assign last = (div_lim > UART_DIV_W'(1)) ? div_lim - UART_DIV_W'(1) : '0;
    assign tick = !hold && (cnt >= last);

    always_ff @(posedge CLK100MHZ or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (hold || cnt >= last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + UART_DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// UART receiver with 16x (OVS) oversampling, midpoint sampling and error strobes.
// Optional even parity bit is enabled by defining UART_RX_PARITY_EN.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int OVS       = UART_OVS
) (
    input  logic                  CLK100MHZ,
    input  logic                  resetn,
    input  logic [UART_DIV_W-1:0] div_lim,
    input  logic                  rx,
    uart_rx_os_if.master          bus
);

    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam int TCW = $clog2(OVS);
    localparam logic [TCW-1:0] HALF_LAST = TCW'(OVS / 2 - 1);
    localparam logic [TCW-1:0] TICK_LAST = TCW'(OVS - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);

    uart_rx_state_t       state;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 tick;
    logic [TCW-1:0]       tick_cnt;
    logic [BCW-1:0]       bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 par_bad;

    // Both flops reset high so a reset never looks like a start edge.
    always_ff @(posedge CLK100MHZ or negedge resetn) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    os_tick_gen u_tick (
        .CLK100MHZ (CLK100MHZ),
        .resetn    (resetn),
        .div_lim   (div_lim),
        .hold      (state == IDLE || state == WAIT_HIGH),
        .tick      (tick)
    );

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic perr_q;
    assign par_bad        = ^{shreg, par_bit};
    assign bus.parity_err = perr_q;
`else
    assign par_bad        = 1'b0;
    assign bus.parity_err = 1'b0;
`endif

    // NOTE: the strobes default low every cycle, so each is a one-cycle registered pulse.
    always_ff @(posedge CLK100MHZ or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit  <= 1'b0;
            perr_q   <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        tick_cnt <= '0;
                    end
                end

                START: begin
                    if (tick) begin
                        if (tick_cnt == HALF_LAST) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= rx_s ? IDLE : DATA;
                        end else begin
                            tick_cnt <= tick_cnt + TCW'(1);
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                            bit_cnt  <= bit_cnt + BCW'(1);
                            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TCW'(1);
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            par_bit  <= rx_s;
                            state    <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + TCW'(1);
                        end
                    end
                end
`endif

                STOP: begin
                    if (tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            ferr_q   <= !rx_s;
`ifdef UART_RX_PARITY_EN
                            perr_q   <= par_bad;
`endif
                            if (rx_s && !par_bad) begin
                                data_q  <= shreg;
                                valid_q <= 1'b1;
                            end
                            // A low stop bit must see the line rise before a new start.
                            state <= rx_s ? IDLE : WAIT_HIGH;
                        end else begin
                            tick_cnt <= tick_cnt + TCW'(1);
                        end
                    end
                end

                WAIT_HIGH: begin
                    if (rx_s) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

UART receiver that turns the asynchronous serial line back into bytes: the receive-side partner of the baud-rate generator. It derives its own 16x oversampling tick from the 100 MHz board clock using the same 12-bit divide-limit convention as the baud generator. It finds the start-bit edge, samples each bit at its midpoint and presents each received word with a one-cycle valid pulse, plus error flags.

## Interface
Parameters:
- DATA_BITS, 8: data bits per frame, sent LSB first.
- OVS, 16: oversampling ticks per bit. Must be even and at least 4.

Ports:
- CLK100MHZ  in  1  system clock.
- resetn  in  1  reset; asynchronous, active-low.
- div_lim  in  12  CLK100MHZ cycles per oversample tick. 0 and 1 both mean a tick every cycle. Change only while the receiver is idle.
- rx  in  1  serial line, asynchronous to CLK100MHZ, idles high.
- rx_data  out  DATA_BITS  last good word; reset value 0.
- rx_valid  out  1  one-cycle pulse when rx_data updates; reset value 0.
- frame_err  out  1  one-cycle pulse when the stop bit samples low; reset value 0.
- parity_err  out  1  one-cycle pulse on parity mismatch; reset value 0; tied 0 when parity is compiled out.

## Operation
- rx passes through a two-flop synchronizer (rx_s). Both flops reset to 1.
- Tick generator:
  - 12-bit counter runs 0..div_lim-1.
  - tick pulses for one cycle when the counter reaches div_lim-1, and the counter wraps to 0.
  - Counter is held at 0 in IDLE and WAIT_HIGH, so tick phase aligns to start-edge detection.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH. Reset state is IDLE.
- tick_cnt counts 0..OVS-1 and clears on every state change.
- Transitions:
  - IDLE: rx_s==0 -> START.
  - START: on the tick where tick_cnt==OVS/2-1, rx_s==0 -> DATA with bit_cnt=0; rx_s==1 -> IDLE (glitch rejected, no flag). All later samples fall at bit midpoints.
  - DATA: on the tick where tick_cnt==OVS-1, shift rx_s in at the MSB (right-shift register, LSB first) and increment bit_cnt. When bit_cnt reaches DATA_BITS -> PARITY if enabled, else STOP.
  - PARITY: on the tick where tick_cnt==OVS-1, capture the parity bit -> STOP.
  - STOP: on the tick where tick_cnt==OVS-1, evaluate the frame:
    - stop bit 1 and parity good: rx_data <= shift register, rx_valid pulses.
    - stop bit 0: frame_err pulses.
    - parity mismatch: parity_err pulses.
    - Both error flags may pulse in the same cycle. On any error, rx_data holds its old value and rx_valid stays 0.
    - Next state: stop bit 1 -> IDLE; stop bit 0 -> WAIT_HIGH.
  - WAIT_HIGH: remain until rx_s==1, then -> IDLE. A held-low break therefore yields exactly one frame_err.
- Widths: bit_cnt is $clog2(DATA_BITS+1) bits; tick_cnt is $clog2(OVS) bits.

## Timing
- Start is recognised 2-3 CLK100MHZ cycles after the rx falling edge (synchronizer delay).
- rx_valid, frame_err and parity_err assert in the cycle after the stop-sample tick, are registered, and last exactly one cycle.
- rx_data changes in the same cycle rx_valid asserts and holds until the next rx_valid.
- Back-to-back frames:
  - The receiver is back in IDLE half a bit before the stop bit ends.
  - A start edge that directly follows the stop bit is accepted with no lost frame.
- Reset asserted mid-frame: FSM goes to IDLE immediately, all counters clear, all outputs return to reset values, and the partial word is discarded.
- Bit period is div_lim × OVS cycles (for example div_lim=54 gives 864 cycles, about 115741 baud).

## Configuration
- UART_RX_PARITY_EN:
  - Defined: one even-parity bit follows the data bits; the PARITY state exists; parity_err is active.
  - Undefined: no PARITY state; frame is start + DATA_BITS + stop; parity_err is constant 0.

## Structure
- Package uart_pkg holds:
  - the FSM state enum typedef (uart_rx_state_t);
  - the default OVS and DATA_BITS constants;
  - the 12-bit div_lim width constant, shared with the baud generator.
- Sub-module os_tick_gen: the div_lim counter with hold/clear input and tick output. The top level holds the synchronizer, FSM and shift register.

## Test plan
Every scenario uses div_lim=54 and a bit period of 864 cycles unless stated.
- Frame 0x55 with valid stop -> single rx_valid pulse, rx_data=0x55, no error flags.
- Low glitch on rx lasting 3 ticks, then rx high -> no rx_valid, no error flags, FSM back in IDLE.
- Frame 0x3C with stop bit driven 0, then line held low for 3 bit periods -> exactly one frame_err pulse, rx_data unchanged from the previous value, no new start detected until rx rises.
- Back-to-back frames 0xA5 then 0x0F with no idle gap -> two rx_valid pulses 10 bit periods apart, with rx_data 0xA5 then 0x0F.
- resetn pulsed low in the middle of data bit 4 of frame 0xFF, then full frame 0x12 -> all outputs 0 during reset, then one rx_valid with rx_data=0x12.
- With UART_RX_PARITY_EN defined: data 0x07 with parity bit 0 -> parity_err pulse, no rx_valid; same data with parity bit 1 -> rx_valid, rx_data=0x07.
